// File: rtl/dac_ladder_control.sv
// Break-before-make sequencer for a 2-bit thermometer resistor-ladder DAC.
// Loads arrive on an asynchronous button; an optional ramp mode auto-steps the level.
module dac_ladder_control #(
    parameter int unsigned DEAD_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned RAMP_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic [1:0] code_in,
    input  logic       ramp_en,
    output logic [3:0] switch_out,
    output logic [1:0] code_out,
    output logic       dac_valid,
    output logic       busy,
    input  logic       VPWR,
    input  logic       VGND
);

    // state    | meaning
    // S_IDLE   | ladder settled at code_out, dac_valid high
    // S_BREAK  | all switches open between levels (DEAD_CYCLES)
    // S_SETTLE | new level driven, waiting for ladder settle (SETTLE_CYCLES)
    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_SETTLE} state_t;

    localparam int unsigned SEQ_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int unsigned HOLD_W  = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;

    localparam logic [SEQ_W-1:0]  DEAD_LOAD   = SEQ_W'(DEAD_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  SETTLE_LOAD = SEQ_W'(SETTLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(RAMP_PERIOD - 1);

    function automatic logic [3:0] therm(input logic [1:0] lvl);
        case (lvl)
            2'd0:    therm = 4'b0001;
            2'd1:    therm = 4'b0011;
            2'd2:    therm = 4'b0111;
            default: therm = 4'b1111;
        endcase
    endfunction

    state_t             state_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               pend_q;
    logic [1:0]         pend_tgt_q;
    logic [1:0]         code_out_q;
    logic [3:0]         switch_q;
    logic               valid_q;
    logic               busy_q;
    logic               sync1_q, sync2_q, sync3_q;

    logic               load_hit;
    logic               idle_go_d;
    logic [1:0]         idle_tgt_d;
    logic               unused_pwr;

    assign unused_pwr = VPWR ^ VGND;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign load_hit = sync2_q & ~sync3_q;

    // A fresh load beats a pending one, and any load beats the ramp tick.
    always_comb begin
        idle_go_d  = 1'b0;
        idle_tgt_d = code_out_q + 2'd1;
        if (load_hit || pend_q) begin
            idle_tgt_d = load_hit ? code_in : pend_tgt_q;
            idle_go_d  = (idle_tgt_d != code_out_q);
        end else if (ramp_en && (hold_q == '0)) begin
            idle_go_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_SETTLE;
            seq_q      <= SETTLE_LOAD;
            hold_q     <= HOLD_LOAD;
            pend_q     <= 1'b0;
            pend_tgt_q <= 2'd0;
            code_out_q <= 2'd0;
            switch_q   <= 4'b0001;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pend_q <= 1'b0;
                    hold_q <= HOLD_LOAD;
                    if (idle_go_d) begin
                        state_q    <= S_BREAK;
                        seq_q      <= DEAD_LOAD;
                        code_out_q <= idle_tgt_d;
                        switch_q   <= 4'b0000;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (ramp_en && !load_hit && !pend_q) begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (load_hit) begin
                        pend_q     <= 1'b1;
                        pend_tgt_q <= code_in;
                    end
                    if (seq_q == '0) begin
                        state_q  <= S_SETTLE;
                        seq_q    <= SETTLE_LOAD;
                        switch_q <= therm(code_out_q);
                    end else begin
                        seq_q <= seq_q - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (load_hit) begin
                        pend_q     <= 1'b1;
                        pend_tgt_q <= code_in;
                    end
                    if (seq_q == '0) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        seq_q <= seq_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_SETTLE;
                    seq_q    <= SETTLE_LOAD;
                    switch_q <= therm(code_out_q);
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign switch_out = switch_q;
    assign code_out   = code_out_q;
    assign dac_valid  = valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/dac_ladder_control.md
DAC_LADDER_CONTROL -- requirements
Module: dac_ladder_control

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, default 2, giving the break-before-make all-off interval in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 8, giving the ladder settle interval in clk cycles before the output is valid (legal range 1..255).
REQ-003 The block SHALL have parameter RAMP_PERIOD, default 16, giving the valid-hold cycles per step in ramp mode (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port btn, input, 1 bit: asynchronous load request; a rising edge loads code_in.
REQ-007 The block SHALL have port code_in, input, 2 bits: requested DAC level.
REQ-008 The block SHALL have port ramp_en, input, 1 bit: when high, the block auto-steps the level 0,1,2,3,0,...
REQ-009 The block SHALL have port switch_out, output, 4 bits: thermometer drive for the resistor-ladder switches.
REQ-010 The block SHALL have port code_out, output, 2 bits: the level currently applied or being applied.
REQ-011 The block SHALL have port dac_valid, output, 1 bit: high when the ladder has settled at code_out.
REQ-012 The block SHALL have port busy, output, 1 bit: high in BREAK or SETTLE.
REQ-013 The block SHALL have ports VPWR and VGND, inputs, 1 bit each: power pins, with no logic function.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The thermometer map SHALL be: level 0 -> 0001, level 1 -> 0011, level 2 -> 0111, level 3 -> 1111.
REQ-016 btn SHALL pass through a 2-flop synchronizer followed by a third flop for edge detection, so a load is recognized at the third rising edge at which btn is sampled high, counting the first such edge as the first.
REQ-017 code_in SHALL be captured as the target on the edge where the load is recognized.
REQ-018 The FSM SHALL have states IDLE, BREAK and SETTLE.
REQ-019 In IDLE, switch_out = therm(code_out), dac_valid = 1 and busy = 0.
REQ-020 IDLE -> BREAK SHALL occur on a recognized load whose target differs from code_out, or on a ramp tick; code_out SHALL update to the target on the same edge.
REQ-021 A recognized load whose target equals code_out SHALL be discarded, with no state change and no dac_valid glitch.
REQ-022 In BREAK, switch_out = 0000, dac_valid = 0 and busy = 1 for exactly DEAD_CYCLES cycles; the state then goes to SETTLE.
REQ-023 In SETTLE, switch_out = therm(code_out), dac_valid = 0 and busy = 1 for exactly SETTLE_CYCLES cycles; the state then goes to IDLE.
REQ-024 A load recognized during BREAK or SETTLE SHALL be held in a 1-deep pending register (target and flag), with a later load overwriting an earlier one.
REQ-025 A pending load SHALL be acted on at the first IDLE cycle, giving one IDLE cycle with dac_valid = 1, and the flag SHALL then clear.
REQ-026 Ramp: while ramp_en = 1 in IDLE, a hold counter SHALL count IDLE cycles; after RAMP_PERIOD cycles it SHALL raise a tick with target (code_out + 1) mod 4, so 3 wraps to 0.
REQ-027 The hold counter SHALL clear on leaving IDLE and whenever ramp_en = 0.
REQ-028 When a load (recognized or pending) and a ramp tick coincide, the load SHALL win, and the hold counter SHALL clear.
REQ-029 Deasserting ramp_en mid-sequence SHALL NOT abort the current BREAK/SETTLE sequence.
REQ-030 Counter widths SHALL be sized from the parameters, and no counter SHALL wrap within a single interval.

Reset
REQ-031 While reset = 1 at a clk edge, the block SHALL set switch_out = 0001, code_out = 00, dac_valid = 0 and busy = 1, clear the pending flag, the hold counter and the synchronizer flops, and enter SETTLE with a full SETTLE_CYCLES count.
REQ-032 After reset deasserts, dac_valid SHALL rise after exactly SETTLE_CYCLES cycles (8 with defaults).
REQ-033 Reset asserted mid-BREAK or mid-SETTLE SHALL abandon the sequence and the pending load, and restart per REQ-031.

Verification
REQ-034 The bench SHALL cover: reset 2 cycles, release -> switch_out = 0001, dac_valid = 0 for 8 cycles, then dac_valid = 1 with code_out = 0.
REQ-035 The bench SHALL cover: in IDLE at 0, code_in = 2 with btn pulsed high for 4 cycles -> 3rd sampled edge: code_out = 2; switch_out = 0000 for 2 cycles, then 0111 for 8 cycles with busy = 1; then dac_valid = 1; only one sequence occurs.
REQ-036 The bench SHALL cover: in IDLE at 3, load with code_in = 3 -> no BREAK, dac_valid stays 1 throughout.
REQ-037 The bench SHALL cover: during SETTLE toward 1, a load of 2 then a load of 0 -> on return to IDLE, dac_valid = 1 for 1 cycle, then a sequence to 0 (the 2 is overwritten).
REQ-038 The bench SHALL cover: ramp_en = 1 from level 3 -> 16 valid cycles, then switch_out 0000 (2 cycles), 0001 (8 cycles), code_out = 0; the step sequence 0,1,2,3,0 holds over 5 steps.
REQ-039 The bench SHALL cover: reset asserted on the 1st SETTLE cycle with a pending load -> REQ-031 state; the pending load is never applied.
